// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: FSM states and shift/rotate modes.
// No logic lives here; the top level and the bench both import these names.
// Mode encoding matches the 2-bit mode field presented on the request bus.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_SHL = 2'b00,
    MODE_SHR = 2'b01,
    MODE_ROL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/status bus between the requester and the shift sequencer.
// master = requester (drives the job request), slave = the sequencer.
// HW_led is carried here so the board LED pins travel with the result.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] load_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] HW_led;

  modport master (
    output start, mode, steps, load_val,
    input  busy, done, result, HW_led
  );

  modport slave (
    input  start, mode, steps, load_val,
    output busy, done, result, HW_led
  );
endinterface

// File: rtl/shift_sequencer_tick_divider.sv
// Step-rate divider: one-cycle tick every DIV cycles while clr is low.
// The counter is held at 0 while clr is high, so the first tick after clr
// drops arrives exactly DIV cycles later.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count 0..DIV-1 and wrap on the terminal count; clr parks the counter at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = !clr && (div_cnt == LAST);
endmodule

// File: rtl/shift_sequencer.sv
// Sequenced shift/rotate unit: load a value, then apply N single-bit steps,
// one step every DIV cycles. start is only honoured in IDLE; the job inputs
// are latched at acceptance, so later changes on the bus have no effect.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int CNT_W = 4
) (
  input logic          clk,
  input logic          rst,
  shift_sequencer_if.slave bus
);

  state_e           state;
  mode_e            mode_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             div_clr;
  logic             tick;

  // One single-bit step; shifts zero-fill, rotates wrap the outgoing bit.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input mode_e m);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      MODE_SHL: r = {v[WIDTH-2:0], 1'b0};
      MODE_SHR: r = {1'b0, v[WIDTH-1:1]};
      MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROR: r = {v[0], v[WIDTH-1:1]};
      default:  r = v;
    endcase
    return r;
  endfunction

  // The divider only runs in SHIFT, so every job starts with a fresh phase.
  assign div_clr = (state != SHIFT);

  tick_divider #(.DIV(DIV)) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  // Job FSM with registered busy/done; remaining counts the steps still owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_SHL;
      remaining <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            result_q  <= bus.load_val;
            mode_q    <= mode_e'(bus.mode);
            remaining <= bus.steps;
            busy_q    <= 1'b1;
            if (bus.steps == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            result_q  <= step1(result_q, mode_q);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.HW_led = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer (WIDTH=8, DIV=4, CNT_W=4): directed vector table,
// hand-written reset/back-to-back sequences, then randomized jobs checked
// against an arithmetic reference of the shift/rotate rules.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] steps;
    logic [7:0] val;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  // Result after k steps, straight from the rules: zero past the width for
  // shifts, rotation amount taken modulo the width.
  function automatic logic [7:0] ref_shift(input logic [7:0] v, input logic [1:0] m, input int k);
    logic [15:0] dbl;
    int r;
    r = k % WIDTH;
    case (m)
      2'b00: return (k >= WIDTH) ? 8'h00 : 8'(v << k);
      2'b01: return (k >= WIDTH) ? 8'h00 : 8'(v >> k);
      2'b10: begin dbl = {v, v} << r; return dbl[15:8]; end
      default: begin dbl = {v, v} >> r; return dbl[7:0]; end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_job(input logic [1:0] md, input logic [3:0] st, input logic [7:0] val,
                         input logic [7:0] exp_res, input string tag, input bit junk);
    int n;
    int bad_traj;
    int busy_low;
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = md; bus.steps = st; bus.load_val = val;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; bad_traj = 0; busy_low = 0;
    while (!bus.done && n < int'(st) * DIV + 8) begin
      if (!bus.busy) busy_low++;
      if (bus.result !== ref_shift(val, md, n / DIV)) bad_traj++;
      if (junk) begin
        bus.start = 1'($urandom); bus.mode = 2'($urandom);
        bus.steps = 4'($urandom); bus.load_val = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    got = bus.done;
    bus.start = 1'b0;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    if (st == 0) check({tag, " latency0"}, 32'(n <= 1), 32'd1);
    else         check({tag, " latency"}, 32'(n), 32'(int'(st) * DIV));
    check({tag, " result"}, 32'(bus.result), 32'(exp_res));
    check({tag, " HW_led"}, 32'(bus.HW_led), 32'(exp_res));
    check({tag, " busy_held"}, 32'(busy_low), 32'd0);
    check({tag, " trajectory"}, 32'(bad_traj), 32'd0);
    @(negedge clk);
    check({tag, " idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    logic [1:0] rm;
    logic [3:0] rs;
    logic [7:0] rv;
    checks = 0; passes = 0;
    bus.start = 1'b0; bus.mode = 2'b00; bus.steps = '0; bus.load_val = '0;

    vecs[0] = '{2'b00, 4'd2,  8'hB6, 8'hD8};
    vecs[1] = '{2'b01, 4'd2,  8'hB6, 8'h2D};
    vecs[2] = '{2'b11, 4'd3,  8'hB6, 8'hD6};
    vecs[3] = '{2'b10, 4'd8,  8'hB6, 8'hB6};
    vecs[4] = '{2'b00, 4'd0,  8'h5A, 8'h5A};
    vecs[5] = '{2'b00, 4'd12, 8'hB6, 8'h00};
    vecs[6] = '{2'b10, 4'd1,  8'h81, 8'h03};
    vecs[7] = '{2'b01, 4'd15, 8'hFF, 8'h00};
    vecs[8] = '{2'b11, 4'd9,  8'h01, 8'h80};

    // Async reset with no clock edge.
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_outputs", {bus.result, bus.HW_led, 6'd0, bus.busy, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_job(vecs[i].mode, vecs[i].steps, vecs[i].val, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

    // start pulsed during SHIFT with another load_val must be dropped.
    run_job(2'b00, 4'd2, 8'hB6, 8'hD8, "ignore_busy_start", 1'b1);

    // start held high: one IDLE cycle, then the next job is accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.steps = 4'd1; bus.load_val = 8'h0F;
    @(negedge clk);
    bus.mode = 2'b10; bus.load_val = 8'hC3;
    done_cnt = 0;
    while (!bus.done && done_cnt < 20) begin @(negedge clk); done_cnt++; end
    check("b2b first_result", 32'(bus.result), 32'h1E);
    @(negedge clk);
    check("b2b idle_gap", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("b2b accepted", {23'd0, bus.busy, bus.result}, {23'd0, 1'b1, 8'hC3});
    bus.start = 1'b0;
    done_cnt = 0;
    while (!bus.done && done_cnt < 20) begin @(negedge clk); done_cnt++; end
    check("b2b second_result", 32'(bus.result), 32'h87);
    @(negedge clk);

    // Reset mid-job aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.steps = 4'd3; bus.load_val = 8'hB6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midjob_reset_outputs", {bus.result, bus.HW_led, 6'd0, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("midjob_no_done", 32'(done_cnt), 32'd0);
    run_job(2'b01, 4'd2, 8'hB6, 8'h2D, "after_reset", 1'b0);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 30; j++) begin
      rm = 2'($urandom); rs = 4'($urandom); rv = 8'($urandom);
      run_job(rm, rs, rv, ref_shift(rv, rm, int'(rs)), $sformatf("rand%0d", j), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
